// File: rtl/apb_sub_driver.sv
// apb_sub_driver: single-outstanding APB manager with PREADY timeout and
// valid/ready command and response ports.
module apb_sub_driver #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    output logic [15:0]       txn_count,
    output logic [7:0]        err_count
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    // The counter holds the number of PREADY-low ACCESS edges seen so far.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t state, state_nxt;
    logic [7:0] tmo, tmo_nxt;
    logic cmd_ready_nxt, rsp_valid_nxt, rsp_err_nxt, psel_nxt, penable_nxt, pwrite_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt, pwdata_nxt;
    logic [ADDR_W-1:0] paddr_nxt;
    logic [15:0] txn_nxt;
    logic [7:0] err_nxt;

    always_comb begin
        state_nxt     = state;
        tmo_nxt       = tmo;
        cmd_ready_nxt = cmd_ready;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        psel_nxt      = PSEL;
        penable_nxt   = PENABLE;
        pwrite_nxt    = PWRITE;
        paddr_nxt     = PADDR;
        pwdata_nxt    = PWDATA;
        txn_nxt       = txn_count;
        err_nxt       = err_count;
        case (state)
            IDLE: if (cmd_valid) begin
                psel_nxt      = 1'b1;
                penable_nxt   = 1'b0;
                pwrite_nxt    = cmd_write;
                paddr_nxt     = cmd_addr;
                pwdata_nxt    = cmd_wdata;
                cmd_ready_nxt = 1'b0;
                state_nxt     = SETUP;
            end
            SETUP: begin
                penable_nxt = 1'b1;
                tmo_nxt     = 8'd0;
                state_nxt   = ACCESS;
            end
            ACCESS: if (PREADY || tmo == TMO_LAST) begin
                psel_nxt      = 1'b0;
                penable_nxt   = 1'b0;
                rsp_rdata_nxt = (PREADY && !PWRITE) ? PRDATA : '0;
                rsp_err_nxt   = !PREADY;
                rsp_valid_nxt = 1'b1;
                txn_nxt       = txn_count + 16'd1;
                err_nxt       = (PREADY || err_count == 8'hFF) ? err_count : err_count + 8'd1;
                state_nxt     = RESP;
            end else begin
                tmo_nxt = tmo + 8'd1;
            end
            RESP: if (rsp_ready) begin
                rsp_valid_nxt = 1'b0;
                cmd_ready_nxt = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            tmo       <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            txn_count <= '0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            tmo       <= tmo_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            PSEL      <= psel_nxt;
            PENABLE   <= penable_nxt;
            PWRITE    <= pwrite_nxt;
            PADDR     <= paddr_nxt;
            PWDATA    <= pwdata_nxt;
            txn_count <= txn_nxt;
            err_count <= err_nxt;
        end
    end
endmodule

// File: tb/tb_apb_sub_driver.sv
// tb_apb_sub_driver: directed checks of apb_sub_driver against a small
// subtractor subordinate model (start 0x0, sub 0x4, ctrl 0x8, result 0xC).
module tb_apb_sub_driver;
    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [15:0] txn_count;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    apb_sub_driver #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY),
        .txn_count(txn_count), .err_count(err_count)
    );

    always #5 PCLK = ~PCLK;

    // Subordinate: PREADY rises one cycle after it samples PSEL & PENABLE.
    logic        sub_en;
    logic        pready_r;
    logic [31:0] sub_r, res_r;
    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pready_r <= 1'b0;
            sub_r    <= '0;
            res_r    <= '0;
        end else begin
            pready_r <= sub_en && PSEL && PENABLE && !pready_r;
            if (PSEL && PENABLE && pready_r && PWRITE) begin
                if (PADDR == 32'h0) res_r <= PWDATA;
                else if (PADDR == 32'h4) sub_r <= PWDATA;
                else if (PADDR == 32'h8 && PWDATA[0]) res_r <= res_r - sub_r;
            end
        end
    end
    assign PREADY = pready_r;
    assign PRDATA = (PADDR == 32'hC) ? res_r : (PADDR == 32'h4) ? sub_r : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the response handshake.
    task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
        int n;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; rsp_ready = 1'b1; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge PCLK); n++; end
        @(negedge PCLK);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge PCLK); n++; end
        chk("rsp_arrives", rsp_valid, 1);
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge PCLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic er;
        int n, cnt, psel_cnt, pen_cnt, first_rv, last, rdy;
        PRESETn = 1'b0; sub_en = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_psel", PSEL, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_txn", txn_count, 0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Write 0x64 to 0x0 and watch the bus shape cycle by cycle.
        cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h64; cmd_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        psel_cnt = 0; pen_cnt = 0; first_rv = 0;
        for (int i = 1; i <= 6; i++) begin
            psel_cnt += int'(PSEL);
            pen_cnt += int'(PENABLE);
            if (rsp_valid && first_rv == 0) first_rv = i;
            @(negedge PCLK);
        end
        chk("t1_psel_cycles", psel_cnt, 3);
        chk("t1_penable_cycles", pen_cnt, 2);
        chk("t1_latency", first_rv, 4);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_txn", txn_count, 1);
        rsp_ready = 1'b1;
        @(negedge PCLK);
        chk("t1_rsp_dropped", rsp_valid, 0);
        chk("t1_cmd_ready", cmd_ready, 1);

        // Subtractor sequence.
        run(1, 32'h0, 32'h64, rd, er);
        run(1, 32'h4, 32'h5, rd, er);
        run(1, 32'h8, 32'h1, rd, er);
        run(0, 32'hC, 32'h0, rd, er);
        chk("t2_result1", rd, 32'h5F);
        chk("t2_err1", er, 0);
        run(1, 32'h8, 32'h1, rd, er);
        run(0, 32'hC, 32'h0, rd, er);
        chk("t2_result2", rd, 32'h5A);
        chk("t2_txn", txn_count, 7);

        // Stalled response: held stable, no new command accepted.
        cmd_write = 1'b0; cmd_addr = 32'h4; cmd_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge PCLK); n++; end
        cmd_addr = 32'h0; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_rsp_valid", rsp_valid, 1);
            chk("t4_rdata", rsp_rdata, 32'h5);
            chk("t4_cmd_ready", cmd_ready, 0);
            chk("t4_no_psel", PSEL, 0);
            @(negedge PCLK);
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        chk("t4_idle_ready", cmd_ready, 1);
        chk("t4_rsp_cleared", rsp_valid, 0);
        @(negedge PCLK);
        chk("t4_accepted", PSEL, 1);
        chk("t4_paddr", PADDR, 32'h0);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge PCLK); n++; end
        @(negedge PCLK);
        chk("t4_txn", txn_count, 9);

        // Timeout with PREADY held low.
        sub_en = 1'b0;
        cmd_write = 1'b0; cmd_addr = 32'hC; cmd_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        n = 0; cnt = 0;
        while (!rsp_valid && n < 40) begin
            cnt += int'(PENABLE);
            @(negedge PCLK);
            n++;
        end
        chk("t3_penable_cycles", cnt, 16);
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_rsp_err", rsp_err, 1);
        chk("t3_rdata", rsp_rdata, 0);
        chk("t3_err_count", err_count, 1);
        chk("t3_psel", PSEL, 0);
        chk("t3_txn", txn_count, 10);
        rsp_ready = 1'b1;
        @(negedge PCLK);
        sub_en = 1'b1;

        // Back-to-back commands every 5 cycles.
        cmd_write = 1'b0; cmd_addr = 32'hC; rsp_ready = 1'b1; cmd_valid = 1'b1;
        last = -1; rdy = 0; psel_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (cmd_ready) begin
                if (last >= 0) chk("t6_gap", i - last, 5);
                chk("t6_no_overlap", PSEL, 0);
                last = i;
                rdy++;
            end
            psel_cnt += int'(PSEL);
            @(negedge PCLK);
        end
        cmd_valid = 1'b0;
        chk("t6_accepts", rdy, 3);
        chk("t6_psel_cycles", psel_cnt, 9);
        @(negedge PCLK);
        chk("t6_txn", txn_count, 13);

        // Asynchronous reset during ACCESS.
        cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'h1; cmd_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("t5_in_access", PENABLE, 1);
        #2 PRESETn = 1'b0;
        #1;
        chk("t5_psel", PSEL, 0);
        chk("t5_penable", PENABLE, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_txn", txn_count, 0);
        chk("t5_err", err_count, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("t5_cmd_ready", cmd_ready, 1);
        run(1, 32'h0, 32'h7, rd, er);
        run(0, 32'hC, 32'h0, rd, er);
        chk("t5_post_read", rd, 32'h7);
        chk("t5_post_txn", txn_count, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
